// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a 1-bit ALU cell. It executes one WIDTH-bit
// NOR/XOR/ADD/SUB LSB first and chains the carry through a register.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_s,
  input  logic             alu_cout
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, shreg;
  logic [1:0]       op_reg;
  logic [IDXW-1:0]  idx;
  logic             carry;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The cell only sees operand bits during RUN; everywhere else it idles on NOR of zeros.
  always_comb begin
    state_nx = state;
    alu_a    = 1'b0;
    alu_b    = 1'b0;
    alu_cin  = 1'b0;
    alu_op   = 2'b00;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        alu_a   = a_reg[idx];
        alu_b   = b_reg[idx];
        alu_cin = carry;
        alu_op  = op_reg;
        if (idx == IDX_LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // result/cout_out are loaded on the edge that enters DONE so they are valid with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= 2'b00;
      idx      <= '0;
      carry    <= 1'b0;
      shreg    <= '0;
      result   <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            op_reg <= op_in;
            idx    <= '0;
            carry  <= (op_in == 2'b11);
          end
        end
        RUN: begin
          shreg <= {alu_s, shreg[WIDTH-1:1]};
          if (op_reg[1]) carry <= alu_cout;
          idx <= idx + IDXW'(1);
          if (idx == IDX_LAST) begin
            result   <= {alu_s, shreg[WIDTH-1:1]};
            cout_out <= op_reg[1] & alu_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: a word-level model checked every cycle,
// literal test-plan expectations, and a randomized start/reset soak.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op_in;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, cout_out;
  logic [W-1:0] result;
  logic         alu_a, alu_b, alu_cin, alu_s, alu_cout;
  logic [1:0]   alu_op;
  logic [1:0]   cell_sum;

  int compared = 0;
  int mismatched = 0;
  int done_count = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .cout_out(cout_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit cell attached to the sequencer.
  always_comb begin
    cell_sum = 2'b00;
    case (alu_op)
      2'b00:   cell_sum = {1'b0, ~(alu_a | alu_b)};
      2'b01:   cell_sum = {1'b0, alu_a ^ alu_b};
      2'b10:   cell_sum = {1'b0, alu_a} + {1'b0, alu_b} + {1'b0, alu_cin};
      default: cell_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {1'b0, alu_cin};
    endcase
  end
  assign alu_s    = cell_sum[0];
  assign alu_cout = cell_sum[1];

  // Word-level model: phase 0 idle, 1..W running, W+1 done.
  bit           model_valid = 1'b0;
  int           phase = 0;
  logic [W-1:0] ma, mb, m_result;
  logic [1:0]   mop;
  logic         m_cout;
  logic [W:0]   wide;

  always @(posedge clk) begin
    if (rst) begin
      model_valid = 1'b1;
      phase = 0;
      m_result = '0;
      m_cout = 1'b0;
    end else if (model_valid) begin
      if (phase == 0) begin
        if (start) begin
          ma = a_in; mb = b_in; mop = op_in; phase = 1;
        end
      end else if (phase == W) begin
        case (mop)
          2'b00:   wide = {1'b0, ~(ma | mb)};
          2'b01:   wide = {1'b0, ma ^ mb};
          2'b10:   wide = {1'b0, ma} + {1'b0, mb};
          default: wide = {1'b0, ma} + {1'b0, ~mb} + 1;
        endcase
        m_result = wide[W-1:0];
        m_cout = wide[W];
        phase = W + 1;
      end else if (phase == W + 1) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  function automatic logic exp_cin(input int i, input logic [1:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] mask, s, a64, nb64;
    mask = (64'd1 << i) - 64'd1;
    a64  = 64'(a);
    nb64 = 64'(~b);
    case (op)
      2'b10:   s = (a64 & mask) + (64'(b) & mask);
      2'b11:   s = (a64 & mask) + (nb64 & mask) + 64'd1;
      default: s = 64'd0;
    endcase
    return s[i];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  logic prev_cout;
  always @(negedge clk) begin
    if (done) done_count++;
    if (model_valid) begin
      checkOutput("busy", busy, phase != 0);
      checkOutput("done", done, phase == W + 1);
      checkOutput("result", result, m_result);
      checkOutput("cout_out", cout_out, m_cout);
      if (phase >= 1 && phase <= W) begin
        checkOutput("alu_a", alu_a, ma[phase-1]);
        checkOutput("alu_b", alu_b, mb[phase-1]);
        checkOutput("alu_op", alu_op, mop);
        checkOutput("alu_cin", alu_cin, exp_cin(phase - 1, mop, ma, mb));
        if (phase >= 2 && mop[1]) checkOutput("cin_chain", alu_cin, prev_cout);
      end else begin
        checkOutput("alu_idle", {alu_a, alu_b, alu_cin, alu_op}, 5'b0);
      end
      prev_cout = alu_cout;
    end
  end

  // Called just after a rising edge; start is sampled on the following edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_in = op; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_in = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom);
  endtask

  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_r, input logic exp_c);
    int k;
    applyStimulus(op, a, b);
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 20);
    checkOutput("done_latency", k, W + 1);
    checkOutput("lit_result", result, exp_r);
    checkOutput("lit_cout", cout_out, exp_c);
    @(posedge clk); #1;
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; op_in = 2'b00; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs", {busy, done, result, cout_out, alu_a, alu_b, alu_cin, alu_op}, 0);
    @(posedge clk); #1;

    runOp(2'b10, 8'h5A, 8'h33, 8'h8D, 1'b0);
    runOp(2'b10, 8'hFF, 8'h01, 8'h00, 1'b1);
    runOp(2'b11, 8'h10, 8'h01, 8'h0F, 1'b1);
    runOp(2'b11, 8'h01, 8'h02, 8'hFF, 1'b0);
    runOp(2'b00, 8'hF0, 8'h0C, 8'h03, 1'b0);
    runOp(2'b01, 8'hF0, 8'h0C, 8'hFC, 1'b0);

    // Reset during cycle 4 of an ADD: no done pulse, result cleared.
    applyStimulus(2'b10, 8'h5A, 8'h33);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    dc = done_count;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_outputs", {busy, done, result, cout_out, alu_op}, 0);
    repeat (12) @(posedge clk);
    checkOutput("mid_reset_no_done", done_count - dc, 0);
    #1;
    runOp(2'b10, 8'h5A, 8'h33, 8'h8D, 1'b0);

    // start held high for 30 edges with changing operands: accepted at 0, 10, 20 only.
    dc = done_count;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op_in = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    checkOutput("held_start_ops", done_count - dc, 3);
    #1;

    // Random soak with sporadic start and rare resets.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      op_in = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b0;
    repeat (15) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that drives a single 1-bit ALU cell to execute one WIDTH-bit operation, LSB first.
- It latches two operands and an op code, then feeds the cell one bit pair per clock, chaining the carry from cycle to cycle.
- It collects the cell's sum bits and reports a WIDTH-bit result plus final carry.
- It sits between a word-level requester and the 1-bit ALU cell, whose port set is `a`, `b`, `cin`, `op`, `s`, `cout`.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal values ≥2.

Ports (reset is synchronous and active-high):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only when busy=0
- op_in  in  2  operation: 00 NOR, 01 XOR, 10 ADD, 11 SUB
- a_in  in  WIDTH  operand A, latched with start
- b_in  in  WIDTH  operand B, latched with start
- busy  out  1  high from cycle after accepted start through done cycle inclusive
- done  out  1  one-cycle pulse; result and cout_out valid from this cycle
- result  out  WIDTH  last completed result, held until next done
- cout_out  out  1  final carry of last ADD/SUB; 0 for NOR/XOR
- alu_a  out  1  current A bit to cell
- alu_b  out  1  current B bit to cell
- alu_cin  out  1  carry into cell
- alu_op  out  2  op to cell
- alu_s  in  1  cell result bit (combinational from alu_* outputs)
- alu_cout  in  1  cell carry out (combinational)

## Operation
- The cell contract is fixed:
  - op 00: s = ~(a|b).
  - op 01: s = a^b.
  - op 10: {cout,s} = a+b+cin.
  - op 11: {cout,s} = a+~b+cin.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, latch a_in, b_in, op_in; clear bit counter; set carry register to op_in==11 ? 1 : 0; go to RUN.
  - RUN: drive alu_a=A[idx], alu_b=B[idx], alu_op=op, alu_cin=carry. On each edge:
    - shift alu_s into the MSB of the internal shift register (right shift);
    - if op[1]=1, carry ← alu_cout;
    - idx ← idx+1.
    - After WIDTH RUN cycles, go to DONE.
  - DONE: result ← shift register; cout_out ← op[1] ? carry : 0; done=1; next state IDLE.
- For NOR/XOR, alu_cin=0 and the carry register stays 0.
- SUB result is A−B mod 2^WIDTH. cout_out=1 means no borrow (A≥B unsigned).
- start is ignored while busy=1, including the DONE cycle. No queuing.
- Outside RUN: alu_a=alu_b=alu_cin=0 and alu_op=00.
- The bit counter is $clog2(WIDTH) bits wide. Terminal count is WIDTH−1. No wrap-around is visible outside.

## Timing
- Reset values: busy=0, done=0, result=0, cout_out=0, alu_a=0, alu_b=0, alu_cin=0, alu_op=00. FSM=IDLE, carry=0.
- Cycle numbering: start sampled high at edge of cycle 0.
  - Cycles 1..WIDTH: RUN, busy=1.
  - Cycle WIDTH+1: DONE, done=1, busy=1.
  - Cycle WIDTH+2: earliest cycle a new start can be sampled.
  - Throughput: one op per WIDTH+2 cycles.
- Cell path is combinational within one cycle. alu_s and alu_cout are sampled at the end of each RUN cycle.
- result and cout_out change only on the edge that enters DONE. They are stable otherwise, including during a following operation.
- rst mid-operation: the next cycle shows reset values. No done pulse. Partial result is discarded and result returns to 0.
- rst and start asserted together: rst wins; start is not accepted.
- Operand inputs may change freely after the start cycle.

## Test plan
- ADD 0x5A+0x33 (WIDTH=8) → done in cycle 9, result=0x8D, cout_out=0; busy high cycles 1–9.
- ADD 0xFF+0x01 → result=0x00, cout_out=1. SUB 0x10−0x01 → 0x0F, cout_out=1. SUB 0x01−0x02 → 0xFF, cout_out=0.
- NOR 0xF0,0x0C → result=0x03, cout_out=0. XOR 0xF0,0x0C → 0xFC, cout_out=0. alu_cin=0 throughout RUN.
- Start held high continuously with different operands → exactly one op per 10 cycles. Ops accepted only at cycles 0, 10, 20. Results match the operands present at those cycles.
- rst at cycle 4 of ADD 0x5A+0x33 (prior result 0xFC) → all outputs return to reset values the next cycle, no done pulse. A fresh op then completes correctly.
- Bit-level check: during SUB 0x01−0x02, alu_cin=1 in cycle 1. Each later alu_cin equals the previous cycle's alu_cout. alu_op=11 in cycles 1–8 and 00 elsewhere.
